reg_file_sequencer: RTL and testbench

Initiator for the register-file command interface. Holds a small program memory of 8-bit instruction words, and on `start` issues them in order to the register file. For each word it drives `word` and the flag bits, then raises a one-cycle `reg_on` strobe. A debug port, usable only when idle, reads or writes a single register through the `read_write`/`rw_reg` path and returns read data with an acknowledge.

---
 rtl/reg_file_sequencer_if.sv | 40 ++++
 rtl/reg_file_sequencer.sv | 138 +++++++++++++
 tb/tb_reg_file_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sequencer_if.sv
// reg_file_sequencer_if: program-load, debug and register-file command signals of the sequencer
interface reg_file_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_data;
    logic              start;
    logic [1:0]        flags_in;
    logic              dbg_req;
    logic              dbg_wr;
    logic [1:0]        dbg_reg;
    logic [7:0]        dbg_wdata;
    logic [7:0]        rd_data;
    logic [7:0]        word;
    logic              reg_on;
    logic [1:0]        read_write;
    logic [1:0]        rw_reg;
    logic [7:0]        wdata;
    logic [1:0]        flags_out;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic              dbg_ack;
    logic [7:0]        dbg_data;

    modport master (
        input  prog_we, prog_addr, prog_data, start, flags_in,
               dbg_req, dbg_wr, dbg_reg, dbg_wdata, rd_data,
        output word, reg_on, read_write, rw_reg, wdata, flags_out,
               pc, busy, done, dbg_ack, dbg_data
    );

    modport slave (
        output prog_we, prog_addr, prog_data, start, flags_in,
               dbg_req, dbg_wr, dbg_reg, dbg_wdata, rd_data,
        input  word, reg_on, read_write, rw_reg, wdata, flags_out,
               pc, busy, done, dbg_ack, dbg_data
    );
endinterface

// File: rtl/reg_file_sequencer.sv
// reg_file_sequencer: issues program words or a single debug access to the register file
module reg_file_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_file_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            r_state, w_state;
    logic [7:0]        r_mem [PROG_DEPTH];
    logic              r_dbg, w_dbg;
    logic [7:0]        r_word, w_word;
    logic              r_reg_on, w_reg_on;
    logic [1:0]        r_rw, w_rw;
    logic [1:0]        r_rw_reg, w_rw_reg;
    logic [7:0]        r_wdata, w_wdata;
    logic [1:0]        r_flags, w_flags;
    logic [ADDR_W-1:0] r_pc, w_pc;
    logic              r_done, w_done;
    logic              r_ack, w_ack;
    logic [7:0]        r_dbg_data, w_dbg_data;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_last;

    assign w_pc_inc = r_pc + 1'b1;
    // End-of-memory test comes first so the wrapped pc+1 read is never used
    assign w_last   = (r_pc == ADDR_W'(PROG_DEPTH - 1)) || (r_mem[w_pc_inc] == 8'hFF);

    always_ff @(posedge clk)
        if (bus.prog_we && r_state == IDLE)
            r_mem[bus.prog_addr] <= bus.prog_data;

    always_comb begin
        w_state    = r_state;
        w_dbg      = r_dbg;
        w_word     = r_word;
        w_reg_on   = 1'b0;
        w_rw       = r_rw;
        w_rw_reg   = r_rw_reg;
        w_wdata    = r_wdata;
        w_flags    = r_flags;
        w_pc       = r_pc;
        w_done     = 1'b0;
        w_ack      = 1'b0;
        w_dbg_data = r_dbg_data;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (r_mem[0] == 8'hFF) begin
                        w_done = 1'b1;
                    end else begin
                        w_state = SETUP;
                        w_dbg   = 1'b0;
                        w_pc    = '0;
                        w_word  = r_mem[0];
                        w_rw    = 2'b00;
                        w_flags = bus.flags_in;
                    end
                end else if (bus.dbg_req && !r_ack) begin
                    // the requester still holds dbg_req during the ack cycle
                    w_state  = SETUP;
                    w_dbg    = 1'b1;
                    w_word   = 8'hF0;
                    w_rw_reg = bus.dbg_reg;
                    w_rw     = bus.dbg_wr ? 2'b01 : 2'b10;
                    w_wdata  = bus.dbg_wdata;
                end
            end
            SETUP: begin
                w_state  = STROBE;
                w_reg_on = 1'b1;
            end
            STROBE: w_state = HOLD;
            HOLD: begin
                if (r_dbg) begin
                    w_dbg_data = (r_rw == 2'b10) ? bus.rd_data : r_dbg_data;
                    w_ack      = 1'b1;
                    w_rw       = 2'b00;
                    w_state    = IDLE;
                end else if (w_last) begin
                    w_done  = 1'b1;
                    w_state = IDLE;
                end else begin
                    w_pc    = w_pc_inc;
                    w_word  = r_mem[w_pc_inc];
                    w_flags = bus.flags_in;
                    w_state = SETUP;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dbg      <= 1'b0;
            r_word     <= '0;
            r_reg_on   <= 1'b0;
            r_rw       <= '0;
            r_rw_reg   <= '0;
            r_wdata    <= '0;
            r_flags    <= '0;
            r_pc       <= '0;
            r_done     <= 1'b0;
            r_ack      <= 1'b0;
            r_dbg_data <= '0;
        end else begin
            r_state    <= w_state;
            r_dbg      <= w_dbg;
            r_word     <= w_word;
            r_reg_on   <= w_reg_on;
            r_rw       <= w_rw;
            r_rw_reg   <= w_rw_reg;
            r_wdata    <= w_wdata;
            r_flags    <= w_flags;
            r_pc       <= w_pc;
            r_done     <= w_done;
            r_ack      <= w_ack;
            r_dbg_data <= w_dbg_data;
        end
    end

    assign bus.word       = r_word;
    assign bus.reg_on     = r_reg_on;
    assign bus.read_write = r_rw;
    assign bus.rw_reg     = r_rw_reg;
    assign bus.wdata      = r_wdata;
    assign bus.flags_out  = r_flags;
    assign bus.pc         = r_pc;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.dbg_ack    = r_ack;
    assign bus.dbg_data   = r_dbg_data;
endmodule

// File: tb/tb_reg_file_sequencer.sv
// tb_reg_file_sequencer: randomized program/debug runs checked against a cycle-level reference model
module tb_reg_file_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] m_mem [16];
    logic [7:0] exp_rf [4];
    logic [7:0] exp_dbg;
    logic [7:0] rf [4];

    reg_file_sequencer_if #(.ADDR_W(4)) b ();
    reg_file_sequencer #(.PROG_DEPTH(16), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk)
        if (rst)
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        else if (b.reg_on && b.read_write == 2'b01)
            rf[b.rw_reg] <= b.wdata;

    assign b.rd_data = (b.read_write == 2'b10) ? rf[b.rw_reg] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_word"}, b.word, 0);
        chk({tag, "_reg_on"}, b.reg_on, 0);
        chk({tag, "_rw"}, b.read_write, 0);
        chk({tag, "_rw_reg"}, b.rw_reg, 0);
        chk({tag, "_wdata"}, b.wdata, 0);
        chk({tag, "_flags"}, b.flags_out, 0);
        chk({tag, "_pc"}, b.pc, 0);
        chk({tag, "_busy"}, b.busy, 0);
        chk({tag, "_done"}, b.done, 0);
        chk({tag, "_ack"}, b.dbg_ack, 0);
        chk({tag, "_dbg_data"}, b.dbg_data, 0);
    endtask

    task automatic load(input int a, input logic [7:0] v);
        b.prog_we   = 1'b1;
        b.prog_addr = 4'(a);
        b.prog_data = v;
        tick();
        b.prog_we   = 1'b0;
        m_mem[a]    = v;
    endtask

    // A program of n words issues strobes in cycles 2,5,..,3n-1 and done in 3n+1;
    // a debug request raised together with start is accepted in the done cycle.
    task automatic run_prog(input bit with_dbg, input bit dwr, input logic [1:0] dreg,
                            input logic [7:0] dwd, input bit poke);
        int n;
        int last;
        logic [1:0] fl;
        n = 0;
        while (n < 16 && m_mem[n] != 8'hFF) n++;
        fl = 2'($urandom);
        b.flags_in = fl;
        b.start = 1'b1;
        if (with_dbg) begin
            b.dbg_req = 1'b1;
            b.dbg_wr = dwr;
            b.dbg_reg = dreg;
            b.dbg_wdata = dwd;
        end
        last = with_dbg ? 3 * n + 6 : 3 * n + 2;
        for (int k = 1; k <= last; k++) begin
            tick();
            if (k == 1) b.start = 1'b0;
            if (poke && n >= 2 && k == 2) begin
                b.prog_we = 1'b1;
                b.prog_addr = 4'd0;
                b.prog_data = ~m_mem[0];
            end
            if (k == 3) b.prog_we = 1'b0;
            chk("reg_on", b.reg_on, (k % 3 == 2 && k <= 3 * n) || (with_dbg && k == 3 * n + 3));
            chk("done", b.done, k == 3 * n + 1);
            chk("busy", b.busy, k <= 3 * n || (with_dbg && k >= 3 * n + 2 && k <= 3 * n + 4));
            if (k % 3 == 2 && k <= 3 * n) begin
                chk("word", b.word, m_mem[(k - 2) / 3]);
                chk("pc", b.pc, 32'((k - 2) / 3));
                chk("flags", b.flags_out, fl);
                chk("prog_rw", b.read_write, 0);
            end
            if (with_dbg) begin
                if (k == 3 * n + 3) begin
                    chk("pd_word", b.word, 8'hF0);
                    chk("pd_rw", b.read_write, dwr ? 2'b01 : 2'b10);
                    chk("pd_rw_reg", b.rw_reg, dreg);
                end
                chk("pd_ack", b.dbg_ack, k == 3 * n + 5);
                if (k == 3 * n + 5) begin
                    if (!dwr) begin
                        exp_dbg = exp_rf[dreg];
                        chk("pd_data", b.dbg_data, exp_dbg);
                    end
                    b.dbg_req = 1'b0;
                end
            end
        end
        if (n > 0) chk("pc_end", b.pc, 32'(n - 1));
        if (with_dbg && dwr) exp_rf[dreg] = dwd;
    endtask

    task automatic do_dbg(input bit wr, input logic [1:0] r, input logic [7:0] d);
        b.dbg_req = 1'b1;
        b.dbg_wr = wr;
        b.dbg_reg = r;
        b.dbg_wdata = d;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("d_reg_on", b.reg_on, k == 2);
            chk("d_ack", b.dbg_ack, k == 4);
            chk("d_busy", b.busy, k <= 3);
            if (k == 2) begin
                chk("d_word", b.word, 8'hF0);
                chk("d_rw", b.read_write, wr ? 2'b01 : 2'b10);
                chk("d_rw_reg", b.rw_reg, r);
                if (wr) chk("d_wdata", b.wdata, d);
            end
            if (k == 4) begin
                if (!wr) exp_dbg = exp_rf[r];
                chk("d_data", b.dbg_data, exp_dbg);
                b.dbg_req = 1'b0;
            end
            if (k == 5) begin
                chk("d_rw_idle", b.read_write, 0);
                chk("d_data_hold", b.dbg_data, exp_dbg);
            end
        end
        if (wr) exp_rf[r] = d;
    endtask

    task automatic reset_mid();
        for (int i = 0; i < 3; i++) load(i, 8'($urandom_range(0, 254)));
        b.start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            b.start = 1'b0;
        end
        chk("rm_strobe", b.reg_on, 1);
        rst = 1'b1;
        tick();
        chk_zero("rm");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_rf[i] = 8'h00;
        exp_dbg = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rm_no_done", b.done, 0);
            chk("rm_no_strobe", b.reg_on, 0);
            chk("rm_idle", b.busy, 0);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_dbg = 8'h00;
        for (int i = 0; i < 4; i++) exp_rf[i] = 8'h00;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'hFF;
        rst = 1'b1;
        b.prog_we = 1'b0;
        b.prog_addr = '0;
        b.prog_data = '0;
        b.start = 1'b0;
        b.flags_in = '0;
        b.dbg_req = 1'b0;
        b.dbg_wr = 1'b0;
        b.dbg_reg = '0;
        b.dbg_wdata = '0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) load(i, 8'hFF);

        load(0, 8'h25);
        load(1, 8'h36);
        load(2, 8'hFF);
        run_prog(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

        do_dbg(1'b1, 2'd2, 8'hA5);
        do_dbg(1'b0, 2'd2, 8'h00);

        for (int i = 0; i < 16; i++) load(i, 8'($urandom_range(0, 254)));
        run_prog(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

        load(3, 8'hFF);
        run_prog(1'b1, 1'b0, 2'd2, 8'h00, 1'b1);
        run_prog(1'b1, 1'b1, 2'd1, 8'h5C, 1'b0);

        reset_mid();

        load(0, 8'hFF);
        run_prog(1'b1, 1'b0, 2'd1, 8'h00, 1'b0);

        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 16; i++)
                load(i, ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 254)));
            run_prog(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom));
            for (int j = 0; j < 3; j++) do_dbg(1'($urandom), 2'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
